rr_decode_arbiter: RTL and testbench
====================================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Produces a registered 3-bit select index plus enable, and the one-hot grant vector that a 3-to-8 decoder with enable produces from them.
- Sits between requesting units and the shared resource in the lab datapath.
- Enforces a fair rotating priority pointer and, optionally, a maximum hold time per grant.

Parameters:
- MAX_HOLD, 15: maximum consecutive cycles a grant may stay active. Legal range 1..2^CNT_W-1. Used only with ARB_TIMEOUT_EN.
- CNT_W, 4: width of the hold counter in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- rel  input  1  release strobe from the current grantee; ends the grant.
- sel  output  3  index of the granted requester (registered).
- en  output  1  grant valid (registered).
- gnt  output  8  one-hot grant.
  - gnt[i] = en when sel==i, else 0.
  - Purely combinational from sel/en; all-zero when en=0.
- busy  output  1  1 while in GRANT state (equals en).
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset: asynchronous and active-high, effective immediately, including mid-grant. Forces:
  - state=IDLE, ptr=0, cnt=0
  - sel=0, en=0, gnt=0, busy=0, timeout=0
- State IDLE:
  - Each cycle, search req circularly starting at ptr: ptr, ptr+1, …, wrap 7→0, up to ptr-1. The first set bit wins.
  - If a winner exists: next edge loads sel=winner, en=1, cnt=0, and moves to GRANT. Latency from req to grant is 1 cycle.
  - If req=0: remain in IDLE, en=0, sel holds its last value.
- State GRANT, evaluated each cycle in this order:
  - rel=1, or req[sel]=0: next edge goes to IDLE, en=0, ptr=(sel+1) mod 8.
  - Otherwise, with timeout enabled and cnt==MAX_HOLD-1: next edge goes to IDLE, en=0, ptr=(sel+1) mod 8, timeout=1 for that one cycle.
  - Otherwise: cnt increments and the grant holds with sel unchanged.
- Gap cycle:
  - Every grant end passes through at least one IDLE cycle with en=0. There is no back-to-back handover.
  - The next winner is evaluated during that IDLE cycle using the updated ptr.
- Fairness: after requester k is served, k has the lowest priority. With all 8 requesting continuously, grants rotate 0,1,…,7,0,…
- Simultaneous events:
  - rel and timeout condition in the same cycle: treated as release, timeout stays 0.
  - req changes on other bits during GRANT: ignored.
- Pointer: wraps 7→0; never updated while in IDLE.
- Invariant: gnt is one-hot or zero at all times; never more than one bit set.
- Counter: CNT_W bits and never overflows. The next-value computation of ptr and of the search index is mod 8 (3-bit wraparound).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter implemented.
  - Grants are forcibly revoked after MAX_HOLD active cycles.
  - timeout pulses as described above.
- Undefined:
  - No counter logic.
  - A grant lasts until rel=1 or its req bit drops.
  - timeout is tied to 0.
  - MAX_HOLD and CNT_W are unused.

Test Plan:
- Reset, then req=8'b0000_0100 → one cycle later sel=2, en=1, gnt=8'h04. rel=1 for 1 cycle → next cycle en=0, gnt=0, ptr=3.
- req=8'hFF held, rel pulsed each grant → grant order sel=0,1,2,…,7,0, each separated by exactly one en=0 cycle.
- ptr=6, req=8'b0000_0011 → winner sel=0 (circular wrap); after release → ptr=1, next winner sel=1.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h01 held, no rel → en=1 for exactly 4 cycles, then en=0 with timeout=1 for 1 cycle, then regrant sel=0.
- reset asserted asynchronously mid-grant (sel=5, en=1) → en, gnt, sel drop to 0 immediately, before the next clk edge; after deassert with req=8'h20 → grant sel=5 after 1 cycle with ptr starting from 0.
- During grant sel=3, req[3] drops to 0 with rel=0 → next cycle en=0, ptr=4; timeout stays 0.

Source files
------------

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin arbiter for 8 requesters.
// It produces a registered select index and an enable, and the one-hot grant
// vector decoded from them.
// Optional macro ARB_TIMEOUT_EN adds a hold counter. The counter forcibly
// revokes a grant after MAX_HOLD cycles and pulses timeout.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx, sel_nx;
  logic [2:0] win, idx;
  logic       win_vld;

  // Reject hold limits the counter cannot represent
  if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_cfg
    $error("rr_decode_arbiter: MAX_HOLD out of range for CNT_W");
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             hold_hit;
  logic             to_nx;

  assign hold_hit = (cnt == CNT_W'(MAX_HOLD - 1));
`endif

  // Circular search of req starting at the priority pointer; first hit wins
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state logic: release/drop has priority over the hold limit
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    ptr_nx   = ptr;
`ifdef ARB_TIMEOUT_EN
    cnt_nx   = cnt;
    to_nx    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          state_nx = GRANT;
          sel_nx   = win;
`ifdef ARB_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      GRANT: begin
        if (rel || !req[sel]) begin
          state_nx = IDLE;
          ptr_nx   = sel + 3'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_hit) begin
          state_nx = IDLE;
          ptr_nx   = sel + 3'd1;
          to_nx    = 1'b1;
        end
        else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, pointer and select registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      sel   <= sel_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and registered timeout pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      timeout <= to_nx;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign en   = (state == GRANT);
  assign busy = en;

  // 3-to-8 decode of sel gated by en
  always_comb begin
    gnt = '0;
    if (en) gnt[sel] = 1'b1;
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench for rr_decode_arbiter: directed scenarios plus random traffic
module tb_rr_decode_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = '0;
  logic       rel = 1'b0;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;
  } obs_t;

  obs_t exp_q[$];

  // reference model: who holds the resource, for how long, and who is next in line
  bit m_busy;
  int m_sel, m_ptr, m_age;
  bit m_to;

  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .sel(sel), .en(en), .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_age = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic rl);
    bit to_now = 0;
    if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        int j = (m_ptr + k) % 8;
        if (r[j]) begin
          m_busy = 1; m_sel = j; m_age = 1;
          break;
        end
      end
    end else if (rl || !r[m_sel]) begin
      m_busy = 0; m_ptr = (m_sel + 1) % 8;
    end else if (TO_EN && m_age == MAX_HOLD) begin
      m_busy = 0; m_ptr = (m_sel + 1) % 8; to_now = 1;
    end else begin
      m_age++;
    end
    m_to = to_now;
  endtask

  task automatic push_expect();
    obs_t e;
    e.sel     = 3'(m_sel);
    e.en      = m_busy;
    e.gnt     = m_busy ? (8'h01 << m_sel) : 8'h00;
    e.busy    = m_busy;
    e.timeout = m_to;
    exp_q.push_back(e);
  endtask

  // Apply one cycle of stimulus, step the model at the edge, queue the expectation
  task automatic cycle(input logic [7:0] r, input logic rl);
    req = r; rel = rl;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(r, rl);
    push_expect();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(8'h00, 1'b0);
    reset = 1'b0;
  endtask

  // Monitor: every cycle after the edge, pop one expectation and compare
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = '{sel: sel, en: en, gnt: gnt, busy: busy, timeout: timeout};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL outputs t=%0t sel/en/gnt/busy/timeout actual=%0d/%0b/%02h/%0b/%0b required=%0d/%0b/%02h/%0b/%0b",
                      $time, a.sel, a.en, a.gnt, a.busy, a.timeout,
                      e.sel, e.en, e.gnt, e.busy, e.timeout);
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic [11:0] imm_act;
    model_reset();
    @(negedge clk);
    do_reset();

    // single requester, grant then release
    cycle(8'h04, 1'b0);
    cycle(8'h04, 1'b0);
    cycle(8'h04, 1'b1);
    cycle(8'h00, 1'b0);

    // full rotation with all requesting, release pulsed each grant
    do_reset();
    for (int g = 0; g < 9; g++) begin
      cycle(8'hFF, 1'b0);
      cycle(8'hFF, 1'b1);
    end

    // pointer at 6, circular wrap to requester 0, then 1
    do_reset();
    cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b1);
    cycle(8'h03, 1'b0);
    cycle(8'h03, 1'b1);
    cycle(8'h03, 1'b0);
    cycle(8'h03, 1'b1);

    // request drop without release ends the grant, pointer moves past it
    cycle(8'h08, 1'b0);
    cycle(8'h08, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h18, 1'b0);
    cycle(8'h18, 1'b1);

    // long hold with no release: hold limit revokes when enabled
    do_reset();
    for (int c = 0; c < 12; c++) cycle(8'h01, 1'b0);
    // release coinciding with the limit cycle
    cycle(8'h00, 1'b0);
    for (int c = 0; c < MAX_HOLD; c++) cycle(8'h01, 1'b0);
    cycle(8'h01, 1'b1);
    cycle(8'h00, 1'b0);

    // asynchronous reset mid-grant on requester 5
    do_reset();
    cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b0);
    #2 reset = 1'b1;
    #1;
    imm_act = {sel, en, gnt};
    n_checks++;
    if (imm_act === 12'h000 && timeout === 1'b0) n_pass++;
    else $display("FAIL async_reset sel/en/gnt/timeout actual=%0d/%0b/%02h/%0b required=0/0/00/0",
                  sel, en, gnt, timeout);
    model_reset();
    @(negedge clk);
    cycle(8'h20, 1'b0);
    reset = 1'b0;
    cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b1);

    // random traffic: sticky request patterns, occasional releases
    r = 8'h00;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: r = 8'h00;
          1: r = 8'(1 << $urandom_range(0, 7));
          2: r = 8'($urandom & $urandom);
          default: r = 8'($urandom);
        endcase
      end
      cycle(r, ($urandom_range(0, 4) == 0));
    end

    cycle(8'h00, 1'b0);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending actual=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
